// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Bit positions inside the {REG_WRITE, MEM_TO_REG} WB control field
  localparam int REG_WRITE_BIT  = 1;
  localparam int MEM_TO_REG_BIT = 0;

  localparam logic [1:0] BUBBLE_CTRL = 2'b00;
  localparam logic [1:0] ALIGN_MASK  = 2'b11;

  // Memory transaction captured when leaving IDLE and held until ACK/timeout
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [1:0]  ctrl;
    logic        we;
  } mem_txn_t;

  function automatic logic is_misaligned(input logic [31:0] a);
    return (a[1:0] & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts REQ-high cycles without ACK; expire flags the last allowed cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Clear on entry to a transaction, count each unacknowledged wait cycle
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)    cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  // A zero TIMEOUT_CYCLES turns the watchdog off entirely
  assign expire = (TIMEOUT_CYCLES != 0) && (cnt == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-memory transactions over a
// req/ack handshake, stalls upstream while one is outstanding, and raises
// a one-cycle fault on misaligned addresses or bus timeouts.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EX_VALID,
  input  logic [31:0] EX_ALU_VAL,
  input  logic [31:0] EX_STORE_DATA,
  input  logic [4:0]  EX_REG_DESTINATION,
  input  logic        EX_MEM_READ,
  input  logic        EX_MEM_WRITE,
  input  logic [1:0]  EX_ALU_CONTROL,
  input  logic        FLUSH,
  output logic        STALL,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_ACK,
  input  logic [31:0] DMEM_RDATA,
  output logic [31:0] MEM_DATA,
  output logic [31:0] ALU_VAL,
  output logic [4:0]  REG_DESTINATION,
  output logic [1:0]  ALU_CONTROL,
  output logic        MEM_FAULT
);

  state_t   state, state_d;
  mem_txn_t txn;
  logic     txn_load;
  logic     flush_q, flush_d;
  logic     ctr_clear, ctr_en, expire;

  logic [31:0] mem_data_d, alu_val_d;
  logic [4:0]  rd_d;
  logic [1:0]  ctrl_d;
  logic        fault_d;

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_tmo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .expire  (expire)
  );

  // Bus outputs are pure functions of state so reset drops REQ at once
  assign STALL      = (state == WAIT);
  assign DMEM_REQ   = (state == WAIT);
  assign DMEM_WE    = (state == WAIT) && txn.we;
  assign DMEM_ADDR  = (state == WAIT) ? txn.addr  : 32'h0;
  assign DMEM_WDATA = (state == WAIT) ? txn.wdata : 32'h0;

  // Next-state and next-output bundle; bubble unless something retires
  always_comb begin
    state_d    = state;
    flush_d    = flush_q;
    txn_load   = 1'b0;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;
    mem_data_d = 32'h0;
    alu_val_d  = 32'h0;
    rd_d       = 5'd0;
    ctrl_d     = BUBBLE_CTRL;
    fault_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (EX_VALID && !FLUSH) begin
          if (!(EX_MEM_READ || EX_MEM_WRITE)) begin
            alu_val_d = EX_ALU_VAL;
            rd_d      = EX_REG_DESTINATION;
            ctrl_d    = EX_ALU_CONTROL;
          end else if (is_misaligned(EX_ALU_VAL)) begin
            fault_d = 1'b1;
          end else begin
            txn_load  = 1'b1;
            ctr_clear = 1'b1;
            flush_d   = 1'b0;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (DMEM_ACK) begin
          // ACK beats a coincident timeout; a flush seen at any point kills the result
          state_d = IDLE;
          flush_d = 1'b0;
          if (!(flush_q || FLUSH)) begin
            mem_data_d                 = txn.we ? 32'h0 : DMEM_RDATA;
            alu_val_d                  = txn.addr;
            rd_d                       = txn.rd;
            ctrl_d[REG_WRITE_BIT]      = txn.ctrl[REG_WRITE_BIT];
            ctrl_d[MEM_TO_REG_BIT]     = txn.ctrl[MEM_TO_REG_BIT];
          end
        end else if (expire) begin
          state_d = IDLE;
          flush_d = 1'b0;
          fault_d = 1'b1;
        end else begin
          ctr_en = 1'b1;
          if (FLUSH) flush_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, flush flag and captured transaction
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      flush_q <= 1'b0;
      txn     <= '0;
    end else begin
      state   <= state_d;
      flush_q <= flush_d;
      if (txn_load) begin
        txn.addr  <= EX_ALU_VAL;
        txn.wdata <= EX_STORE_DATA;
        txn.rd    <= EX_REG_DESTINATION;
        txn.ctrl  <= EX_ALU_CONTROL;
        txn.we    <= EX_MEM_WRITE;
      end
    end
  end

  // MEM/WB-facing bundle, refreshed every edge
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      MEM_DATA        <= 32'h0;
      ALU_VAL         <= 32'h0;
      REG_DESTINATION <= 5'd0;
      ALU_CONTROL     <= BUBBLE_CTRL;
      MEM_FAULT       <= 1'b0;
    end else begin
      MEM_DATA        <= mem_data_d;
      ALU_VAL         <= alu_val_d;
      REG_DESTINATION <= rd_d;
      ALU_CONTROL     <= ctrl_d;
      MEM_FAULT       <= fault_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 4-cycle timeout.
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        EX_VALID;
  logic [31:0] EX_ALU_VAL;
  logic [31:0] EX_STORE_DATA;
  logic [4:0]  EX_REG_DESTINATION;
  logic        EX_MEM_READ;
  logic        EX_MEM_WRITE;
  logic [1:0]  EX_ALU_CONTROL;
  logic        FLUSH;
  logic        STALL;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic        DMEM_ACK;
  logic [31:0] DMEM_RDATA;
  logic [31:0] MEM_DATA;
  logic [31:0] ALU_VAL;
  logic [4:0]  REG_DESTINATION;
  logic [1:0]  ALU_CONTROL;
  logic        MEM_FAULT;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .EX_VALID(EX_VALID), .EX_ALU_VAL(EX_ALU_VAL),
    .EX_STORE_DATA(EX_STORE_DATA), .EX_REG_DESTINATION(EX_REG_DESTINATION),
    .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE),
    .EX_ALU_CONTROL(EX_ALU_CONTROL), .FLUSH(FLUSH), .STALL(STALL),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
    .MEM_DATA(MEM_DATA), .ALU_VAL(ALU_VAL), .REG_DESTINATION(REG_DESTINATION),
    .ALU_CONTROL(ALU_CONTROL), .MEM_FAULT(MEM_FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic r, input logic w,
                       input logic [1:0] c);
    EX_VALID = v; EX_ALU_VAL = a; EX_STORE_DATA = d; EX_REG_DESTINATION = rd;
    EX_MEM_READ = r; EX_MEM_WRITE = w; EX_ALU_CONTROL = c;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".data"}, MEM_DATA, 32'h0);
    chk({tag, ".alu"},  ALU_VAL, 32'h0);
    chk({tag, ".rd"},   {27'h0, REG_DESTINATION}, 32'h0);
    chk({tag, ".ctrl"}, {30'h0, ALU_CONTROL}, 32'h0);
  endtask

  initial begin
    RESET_N = 1'b0; FLUSH = 1'b0; DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
    #2;
    chk("rst.stall", STALL, 0);
    chk("rst.req", DMEM_REQ, 0);
    chk("rst.fault", MEM_FAULT, 0);
    chk_bubble("rst");
    tick(); tick();
    RESET_N = 1'b1;

    // non-memory op, 1-cycle latency
    drive(1'b1, 32'h10, 32'h0, 5'd5, 1'b0, 1'b0, 2'b10);
    tick();
    chk("alu.val", ALU_VAL, 32'h10);
    chk("alu.rd", REG_DESTINATION, 5);
    chk("alu.ctrl", ALU_CONTROL, 2'b10);
    chk("alu.data", MEM_DATA, 0);
    chk("alu.stall", STALL, 0);

    // load 0x100, ACK in third REQ cycle
    drive(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 2'b11);
    tick();
    chk("ld.stall1", STALL, 1);
    chk("ld.req", DMEM_REQ, 1);
    chk("ld.addr", DMEM_ADDR, 32'h100);
    chk("ld.we", DMEM_WE, 0);
    chk_bubble("ld.w1");
    tick();
    chk("ld.stall2", STALL, 1);
    chk_bubble("ld.w2");
    tick();
    chk("ld.stall3", STALL, 1);
    chk("ld.addr3", DMEM_ADDR, 32'h100);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hDEADBEEF;
    tick();
    DMEM_ACK = 1'b0;
    chk("ld.data", MEM_DATA, 32'hDEADBEEF);
    chk("ld.ctrl", ALU_CONTROL, 2'b11);
    chk("ld.rd", REG_DESTINATION, 7);
    chk("ld.alu", ALU_VAL, 32'h100);
    chk("ld.stall_end", STALL, 0);
    chk("ld.req_end", DMEM_REQ, 0);

    // store 0x204, ACK on first REQ cycle
    drive(1'b1, 32'h204, 32'h12345678, 5'd0, 1'b0, 1'b1, 2'b00);
    tick();
    chk("st.req", DMEM_REQ, 1);
    chk("st.we", DMEM_WE, 1);
    chk("st.addr", DMEM_ADDR, 32'h204);
    chk("st.wdata", DMEM_WDATA, 32'h12345678);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hFFFFFFFF;
    tick();
    DMEM_ACK = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
    chk("st.stall", STALL, 0);
    chk("st.ctrl", ALU_CONTROL, 2'b00);
    chk("st.data", MEM_DATA, 0);
    chk("st.alu", ALU_VAL, 32'h204);
    tick();
    chk_bubble("idle");

    // misaligned load
    drive(1'b1, 32'h102, 32'h0, 5'd3, 1'b1, 1'b0, 2'b11);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
    chk("mis.fault", MEM_FAULT, 1);
    chk("mis.req", DMEM_REQ, 0);
    chk("mis.stall", STALL, 0);
    chk_bubble("mis");
    tick();
    chk("mis.fault_off", MEM_FAULT, 0);
    chk("mis.req2", DMEM_REQ, 0);

    // timeout: REQ high for exactly 4 cycles
    drive(1'b1, 32'h300, 32'h0, 5'd3, 1'b1, 1'b0, 2'b11);
    tick();
    chk("to.req1", DMEM_REQ, 1);
    tick();
    chk("to.req2", DMEM_REQ, 1);
    tick();
    chk("to.req3", DMEM_REQ, 1);
    tick();
    chk("to.req4", DMEM_REQ, 1);
    chk("to.nofault4", MEM_FAULT, 0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
    chk("to.req5", DMEM_REQ, 0);
    chk("to.fault", MEM_FAULT, 1);
    chk("to.stall", STALL, 0);
    chk_bubble("to");
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hCAFEF00D;
    tick();
    DMEM_ACK = 1'b0;
    chk("stray.fault", MEM_FAULT, 0);
    chk("stray.req", DMEM_REQ, 0);
    chk_bubble("stray");

    // ACK on the would-be timeout cycle wins
    drive(1'b1, 32'h600, 32'h0, 5'd2, 1'b1, 1'b0, 2'b11);
    tick(); tick(); tick(); tick();
    chk("race.req4", DMEM_REQ, 1);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h0BADF00D;
    tick();
    DMEM_ACK = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
    chk("race.data", MEM_DATA, 32'h0BADF00D);
    chk("race.ctrl", ALU_CONTROL, 2'b11);
    chk("race.fault", MEM_FAULT, 0);

    // FLUSH in second WAIT cycle kills the load result
    drive(1'b1, 32'h400, 32'h0, 5'd9, 1'b1, 1'b0, 2'b11);
    tick();
    tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("fl.stall", STALL, 1);
    chk("fl.req", DMEM_REQ, 1);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hAAAA5555;
    tick();
    DMEM_ACK = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
    chk("fl.stall_end", STALL, 0);
    chk("fl.fault", MEM_FAULT, 0);
    chk_bubble("fl");

    // next load after a flushed one is unaffected
    drive(1'b1, 32'h700, 32'h0, 5'd6, 1'b1, 1'b0, 2'b11);
    tick();
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h13579BDF;
    tick();
    DMEM_ACK = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
    chk("fl2.data", MEM_DATA, 32'h13579BDF);
    chk("fl2.rd", REG_DESTINATION, 6);

    // a non-memory op to leave non-zero outputs, then reset mid-WAIT
    drive(1'b1, 32'h55, 32'h0, 5'd1, 1'b0, 1'b0, 2'b10);
    tick();
    drive(1'b1, 32'h500, 32'h0, 5'd4, 1'b1, 1'b0, 2'b11);
    chk("pre.alu", ALU_VAL, 32'h55);
    tick();
    chk("rw.req", DMEM_REQ, 1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rw.req0", DMEM_REQ, 0);
    chk("rw.stall0", STALL, 0);
    chk("rw.addr0", DMEM_ADDR, 0);
    chk_bubble("rw");
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00);
    tick();
    RESET_N = 1'b1;
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h77777777;
    tick();
    DMEM_ACK = 1'b0;
    chk("rw.late_req", DMEM_REQ, 0);
    chk("rw.late_fault", MEM_FAULT, 0);
    chk_bubble("rw.late");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage sitting between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Issues data-memory reads and writes over a req/ack handshake, stalls upstream while a transaction is outstanding, and detects misaligned addresses and bus timeouts.
- Presents a registered {MEM_DATA, ALU_VAL, REG_DESTINATION, ALU_CONTROL} bundle that MEM/WB captures every cycle. A bubble is emitted whenever no instruction retires.

Parameters:
- TIMEOUT_CYCLES, 16, maximum REQ-high cycles before abort; 0 disables the timeout.
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous, active-low reset
- EX_VALID  input  1  upstream instruction present
- EX_ALU_VAL  input  32  ALU result; used as the address for memory ops
- EX_STORE_DATA  input  32  store write data
- EX_REG_DESTINATION  input  5  destination register
- EX_MEM_READ  input  1  load
- EX_MEM_WRITE  input  1  store; never high together with EX_MEM_READ
- EX_ALU_CONTROL  input  2  WB control {REG_WRITE, MEM_TO_REG}
- FLUSH  input  1  kill the current or incoming instruction
- STALL  output  1  upstream must hold its inputs
- DMEM_REQ  output  1  memory request
- DMEM_WE  output  1  write enable
- DMEM_ADDR  output  32  word-aligned address
- DMEM_WDATA  output  32  write data
- DMEM_ACK  input  1  completion, one-cycle pulse
- DMEM_RDATA  input  32  read data, valid when DMEM_ACK is high
- MEM_DATA  output  32  load data, 0 otherwise
- ALU_VAL  output  32  pass-through ALU result
- REG_DESTINATION  output  5  destination register
- ALU_CONTROL  output  2  WB control; 2'b00 for a bubble
- MEM_FAULT  output  1  one-cycle pulse on misalignment or timeout

Behaviour:
- Reset, asynchronous on RESET_N low:
  - state = IDLE, counter = 0, flush flag = 0.
  - All outputs 0, including STALL, DMEM_REQ and MEM_FAULT.
  - Reset during WAIT drops DMEM_REQ immediately; any later ACK is ignored.
- Two FSM states: IDLE and WAIT.
- Bubble definition: MEM_DATA = 0, ALU_VAL = 0, REG_DESTINATION = 0, ALU_CONTROL = 00.
- Output registers update every edge. STALL = (state == WAIT), a pure function of state.
- IDLE behaviour:
  - EX_VALID = 0 or FLUSH = 1: next edge emits a bubble.
  - Non-memory op: next edge registers EX_ALU_VAL, EX_REG_DESTINATION and EX_ALU_CONTROL; MEM_DATA = 0. Latency is 1 cycle.
  - Memory op with EX_ALU_VAL[1:0] != 0: no request is issued. Next edge emits a bubble and MEM_FAULT = 1.
  - Aligned memory op: capture address, write data, destination, control and read/write type. Go to WAIT, load counter = 0, emit a bubble.
- WAIT behaviour:
  - DMEM_REQ = 1, DMEM_WE = captured write flag, DMEM_ADDR and DMEM_WDATA come from the captured values.
  - Address and data stay stable until ACK.
  - Counter increments each WAIT cycle without ACK.
  - Outputs hold the bubble while waiting.
- ACK cycle in WAIT:
  - Next edge: load → MEM_DATA = DMEM_RDATA; store → MEM_DATA = 0.
  - ALU_VAL, REG_DESTINATION and ALU_CONTROL take the captured values; return to IDLE.
  - STALL is still 1 during the ACK cycle, so upstream presents the next instruction the cycle after.
  - Minimum load latency is 2 edges, with ACK in the first REQ cycle.
- Timeout: when TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES - 1 with no ACK:
  - Next edge returns to IDLE and DMEM_REQ drops.
  - A bubble is emitted and MEM_FAULT = 1.
  - ACK arriving in that same cycle wins; it is a normal completion with no fault.
- FLUSH during WAIT:
  - The transaction is not aborted, because the bus must complete.
  - A sticky flush flag is set.
  - On ACK, a bubble is emitted instead of the result and the flag clears.
  - Timeout also clears the flag.
- DMEM_ACK while in IDLE is ignored.
- MEM_FAULT is high for exactly one cycle per fault.

Decomposition:
- Shared package mem_stage_pkg:
  - State encoding: IDLE = 1'b0, WAIT = 1'b1.
  - WB control bit indices: REG_WRITE_BIT = 1, MEM_TO_REG_BIT = 0.
  - BUBBLE_CTRL = 2'b00.
  - Alignment mask 2'b11.
- Sub-module mem_timeout_ctr:
  - Ports: clear, enable, expire.
  - Parameterised by TIMEOUT_CYCLES and CNT_W.
- Everything else lives in mem_access_stage.

Test Plan:
- Non-memory op: EX_VALID = 1, ALU = 0x0000_0010, dest = 5, ctrl = 10 → next edge outputs ALU_VAL = 0x10, REG_DESTINATION = 5, ALU_CONTROL = 10, MEM_DATA = 0, STALL = 0.
- Load at 0x100, ACK after 3 REQ cycles with RDATA = 0xDEADBEEF → STALL high for 3 cycles, DMEM_ADDR = 0x100, DMEM_WE = 0. The edge after ACK gives MEM_DATA = 0xDEADBEEF, ctrl = 11, and bubbles before that.
- Store to 0x204, data 0x1234_5678, ACK on the first REQ cycle → DMEM_WE = 1, DMEM_WDATA = 0x12345678; output ctrl = 00, MEM_DATA = 0; latency 2 edges.
- Misaligned load at 0x102 → DMEM_REQ never asserted; MEM_FAULT pulses 1 cycle; bubble; STALL stays 0.
- Timeout with TIMEOUT_CYCLES = 4 and no ACK → REQ high for exactly 4 cycles, then MEM_FAULT pulse and bubble, back to IDLE. A later stray ACK changes nothing.
- FLUSH pulsed in the second WAIT cycle of a load, then ACK → bubble output, no register write. RESET_N low mid-WAIT → DMEM_REQ = 0 and all outputs 0 immediately.
